// File: rtl/aho_pkg.sv
// ============================================================================
// Module      : aho_pkg
// Description : Shared constants, event record type and FSM state encoding
//               for the AHO event logger.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aho_pkg;

    // Widths of the upstream cycle counter and the run-length field
    localparam int AHO_TS_W  = 16;
    localparam int AHO_RUN_W = 4;

    // One logged record: start timestamp in the upper bits, run length below
    typedef struct packed {
        logic [AHO_TS_W-1:0]  ts;
        logic [AHO_RUN_W-1:0] len;
    } aho_evt_t;

    // Run-tracking FSM: waiting for a run, or counting one
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } aho_evt_state_e;

endpackage : aho_pkg

`default_nettype wire

// File: rtl/aho_evt_fifo.sv
// ============================================================================
// Module      : aho_evt_fifo
// Description : Generic synchronous first-word-fall-through FIFO. The head
//               entry is visible on dout whenever the FIFO is non-empty and
//               dout is forced to zero when empty. A push into a full FIFO
//               is accepted only if a pop happens on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aho_evt_fifo
    import aho_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = AHO_TS_W + AHO_RUN_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW:0]     FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   PTR_INC  = AW'(1);
    localparam logic [AW:0]     CNT_INC  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_LVL);
    assign level = count;

    // A clear suppresses both sides; a full FIFO only accepts with a pop
    assign do_pop  = pop  & ~empty & ~clr;
    assign do_push = push & ~clr & (~full | do_pop);

    assign dout = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH = 2^AW)
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_INC;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_INC;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_INC;
                2'b01:   count <= count - CNT_INC;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty masks dout
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : aho_evt_fifo

`default_nettype wire

// File: rtl/aho_evt_logger.sv
// ============================================================================
// Module      : aho_evt_logger
// Description : Converts runs of consecutive AHO-high cycles into records of
//               {start timestamp, run length} and buffers them in an FWFT
//               FIFO read by a host over a valid/ready handshake. Runs longer
//               than the run-length field allows are split into full chunks.
//               Optional macro AHO_EVT_DROP_CNT_EN adds an 8-bit saturating
//               DROP_CNT output counting records lost to a full FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aho_evt_logger
    import aho_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int TS_W  = AHO_TS_W,
    parameter int RUN_W = AHO_RUN_W
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     AHO,
    input  logic                     EN,
    input  logic                     SYNC_CLR,
    output logic                     EVT_VALID,
    input  logic                     EVT_READY,
    output logic [TS_W-1:0]          EVT_TS,
    output logic [RUN_W-1:0]         EVT_LEN,
    output logic                     OVF,
    output logic [$clog2(DEPTH):0]   LEVEL
`ifdef AHO_EVT_DROP_CNT_EN
    ,
    output logic [7:0]               DROP_CNT
`endif
);

    localparam logic [RUN_W-1:0] RUN_MAX = '1;
    localparam logic [RUN_W-1:0] LEN_ONE = RUN_W'(1);
    localparam logic [TS_W-1:0]  TS_INC  = TS_W'(1);

    aho_evt_state_e         state;
    aho_evt_state_e         state_nxt;
    logic [TS_W-1:0]        ts;
    logic [TS_W-1:0]        ts_start;
    logic [TS_W-1:0]        ts_start_nxt;
    logic [RUN_W-1:0]       len;
    logic [RUN_W-1:0]       len_nxt;
    logic                   capture;
    logic                   push;
    logic [TS_W+RUN_W-1:0]  push_data;
    logic [TS_W+RUN_W-1:0]  head_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop_eff;
    logic                   drop;
    logic                   ovf_q;

    assign capture = EN & AHO;

    // Run tracking: open, extend, split at RUN_MAX, or close and emit a record
    always_comb begin
        state_nxt    = state;
        ts_start_nxt = ts_start;
        len_nxt      = len;
        push         = 1'b0;
        push_data    = {ts_start, len};
        case (state)
            IDLE: begin
                if (capture) begin
                    ts_start_nxt = ts;
                    len_nxt      = LEN_ONE;
                    state_nxt    = RUN;
                end
            end
            RUN: begin
                if (capture) begin
                    if (len == RUN_MAX) begin
                        push         = 1'b1;
                        ts_start_nxt = ts;
                        len_nxt      = LEN_ONE;
                    end else begin
                        len_nxt = len + LEN_ONE;
                    end
                end else begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state, run registers and free-running timestamp counter
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            ts       <= '0;
            ts_start <= '0;
            len      <= '0;
        end else if (SYNC_CLR) begin
            state    <= IDLE;
            ts       <= '0;
            ts_start <= '0;
            len      <= '0;
        end else begin
            state    <= state_nxt;
            ts       <= ts + TS_INC;
            ts_start <= ts_start_nxt;
            len      <= len_nxt;
        end
    end

    aho_evt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (TS_W + RUN_W)
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .clr   (SYNC_CLR),
        .push  (push),
        .din   (push_data),
        .pop   (EVT_READY),
        .dout  (head_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (LEVEL)
    );

    assign EVT_VALID = ~fifo_empty;
    assign EVT_TS    = head_data[TS_W+RUN_W-1:RUN_W];
    assign EVT_LEN   = head_data[RUN_W-1:0];

    // A record is lost only when full and nothing leaves on the same edge
    assign pop_eff = EVT_READY & ~fifo_empty;
    assign drop    = push & fifo_full & ~pop_eff & ~SYNC_CLR;

    // Sticky overflow flag, cleared only by reset or synchronous clear
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
        end else if (SYNC_CLR) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    assign OVF = ovf_q;

`ifdef AHO_EVT_DROP_CNT_EN
    logic [7:0] drop_cnt;

    // Saturating count of lost records
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            drop_cnt <= '0;
        end else if (SYNC_CLR) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign DROP_CNT = drop_cnt;
`endif

endmodule : aho_evt_logger

`default_nettype wire

// File: tb/tb_aho_evt_logger.sv
// ============================================================================
// Module      : tb_aho_evt_logger
// Description : Self-checking bench for aho_evt_logger: a table of per-cycle
//               vectors for the basic run-to-record path, followed by
//               hand-written sequences for run splitting, overflow,
//               simultaneous push/pop when full, EN drop, SYNC_CLR and an
//               asynchronous reset in the middle of a run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_aho_evt_logger;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        AHO = 1'b0;
    logic        EN = 1'b0;
    logic        SYNC_CLR = 1'b0;
    logic        EVT_READY = 1'b0;
    logic        EVT_VALID;
    logic [15:0] EVT_TS;
    logic [3:0]  EVT_LEN;
    logic        OVF;
    logic [3:0]  LEVEL;
`ifdef AHO_EVT_DROP_CNT_EN
    logic [7:0]  DROP_CNT;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic aho;
        logic en;
        logic rdy;
        logic clr;
        logic valid;
        int   ts;
        int   len;
        int   lvl;
        logic ovf;
    } vec_t;

    vec_t tbl[10];

    always #5 CLK = ~CLK;

    aho_evt_logger #(
        .DEPTH (8),
        .TS_W  (16),
        .RUN_W (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .AHO       (AHO),
        .EN        (EN),
        .SYNC_CLR  (SYNC_CLR),
        .EVT_VALID (EVT_VALID),
        .EVT_READY (EVT_READY),
        .EVT_TS    (EVT_TS),
        .EVT_LEN   (EVT_LEN),
        .OVF       (OVF),
        .LEVEL     (LEVEL)
`ifdef AHO_EVT_DROP_CNT_EN
        ,
        .DROP_CNT  (DROP_CNT)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one edge, then sample 1 ns after it
    task automatic step(input logic a, input logic e, input logic r, input logic c);
        AHO       = a;
        EN        = e;
        EVT_READY = r;
        SYNC_CLR  = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic v, input int t, input int l,
                             input int lvl, input logic o);
        chk({tag, ".valid"}, 32'(EVT_VALID), 32'(v));
        chk({tag, ".ts"},    32'(EVT_TS),    32'(t));
        chk({tag, ".len"},   32'(EVT_LEN),   32'(l));
        chk({tag, ".level"}, 32'(LEVEL),     32'(lvl));
        chk({tag, ".ovf"},   32'(OVF),       32'(o));
    endtask

    initial begin
        // Inputs applied at the edge where the counter equals the row index
        tbl[0] = '{aho:0, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[1] = '{aho:0, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[2] = '{aho:0, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[3] = '{aho:1, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[4] = '{aho:1, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[5] = '{aho:1, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[6] = '{aho:0, en:1, rdy:0, clr:0, valid:1, ts:3, len:3, lvl:1, ovf:0};
        tbl[7] = '{aho:0, en:1, rdy:1, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[8] = '{aho:0, en:1, rdy:1, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};
        tbl[9] = '{aho:0, en:1, rdy:0, clr:0, valid:0, ts:0, len:0, lvl:0, ovf:0};

        // Reset state
        #2;
        chk_state("reset", 1'b0, 0, 0, 0, 1'b0);
`ifdef AHO_EVT_DROP_CNT_EN
        chk("reset.drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
        #10;
        RST = 1'b1;

        // Basic run of 3 starting at ts 3, pop, and READY while empty
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].aho, tbl[i].en, tbl[i].rdy, tbl[i].clr);
            chk_state($sformatf("vec%0d", i), tbl[i].valid, tbl[i].ts, tbl[i].len,
                      tbl[i].lvl, tbl[i].ovf);
        end

        // 20-cycle run from ts 10 splits into {10,15} and {25,5}
        for (int t = 10; t < 30; t++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            if (t == 24) chk("split.no_early_push", 32'(LEVEL), 32'd0);
            if (t == 25) chk_state("split.first", 1'b1, 10, 15, 1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("split.both", 1'b1, 10, 15, 2, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_state("split.second", 1'b1, 25, 5, 1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_state("split.drained", 1'b0, 0, 0, 0, 1'b0);

        // Overflow: restart ts, 9 single pulses at ts 0,2,..,16 with no reads
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int t = 0; t < 18; t++) begin
            step((t % 2 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0, 1'b0);
            if (t == 16) chk_state("ovf.full", 1'b1, 0, 1, 8, 1'b0);
        end
        chk_state("ovf.dropped", 1'b1, 0, 1, 8, 1'b1);
`ifdef AHO_EVT_DROP_CNT_EN
        chk("ovf.drop_cnt", 32'(DROP_CNT), 32'd1);
`endif

        // Full FIFO: push {18,1} and pop {0,1} on the same edge
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk_state("full_pushpop", 1'b1, 2, 1, 8, 1'b1);
`ifdef AHO_EVT_DROP_CNT_EN
        chk("full_pushpop.drop_cnt", 32'(DROP_CNT), 32'd1);
`endif
        // Drain in order: {2..14 step 2}, then {18,1}; {16,1} was lost
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d.ts", k), 32'(EVT_TS), (k < 7) ? 32'(2 + 2 * k) : 32'd18);
            chk($sformatf("drain%0d.len", k), 32'(EVT_LEN), 32'd1);
            step(1'b0, 1'b1, 1'b1, 1'b0);
        end
        chk("drain.level", 32'(LEVEL), 32'd0);

        // SYNC_CLR clears OVF; then EN dropped while AHO stays high
        step(1'b0, 1'b1, 1'b0, 1'b1);
        chk_state("clr.ovf", 1'b0, 0, 0, 0, 1'b0);
`ifdef AHO_EVT_DROP_CNT_EN
        chk("clr.drop_cnt", 32'(DROP_CNT), 32'd0);
`endif
        for (int t = 0; t < 40; t++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int t = 40; t < 43; t++) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk_state("en_drop.record", 1'b1, 40, 3, 1, 1'b0);
        for (int t = 44; t < 48; t++) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("en_drop.no_new_run", 1'b1, 40, 3, 1, 1'b0);

        // Two entries stored, run open, then SYNC_CLR with READY and AHO high
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("sclr.level2", 32'(LEVEL), 32'd2);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk_state("sclr.cleared", 1'b0, 0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("sclr.ts_restart", 1'b1, 0, 2, 1, 1'b0);

        // Asynchronous reset in the middle of an open run
        step(1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        RST = 1'b0;
        #1;
        chk_state("async_rst", 1'b0, 0, 0, 0, 1'b0);
        #3;
        RST = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_state("async_rst.run_lost", 1'b0, 0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_aho_evt_logger

`default_nettype wire
